data_mem: RTL
=============

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 The block SHALL have parameter ADDR_W, default riscv_pkg::byte_addr_p, giving the byte-address width.
REQ-002 The block SHALL have derived constant DEPTH = 2**(ADDR_W-2), the number of 32-bit words stored.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset; synchronous and active-high.
REQ-005 addr_i  input  ADDR_W  byte address from the core memory port.
REQ-006 wr_en_i  input  1  write request, one cycle per access.
REQ-007 rd_en_i  input  1  read request, one cycle per access.
REQ-008 data_i  input  32  write data.
REQ-009 data_o  output  32  read data; registered.
REQ-010 rd_valid_o  output  1  one-cycle pulse; data_o carries a fresh read result.
REQ-011 ready_o  output  1  high when requests are accepted; low during memory clear.
REQ-012 err_o  output  1  sticky misaligned-access flag.
REQ-013 err_addr_o  output  ADDR_W  address of the first misaligned access.

Function
REQ-014 Storage SHALL be DEPTH x 32-bit words; word index = addr_i[ADDR_W-1:2].
REQ-015 FSM SHALL have two states: CLEAR and READY.
REQ-016 CLEAR behaviour: a counter starts at 0, writes 0 to one word per cycle, increments, and transitions to READY on the edge that clears word DEPTH-1.
REQ-017 ready_o SHALL be a registered output: 0 in CLEAR, 1 in READY; it goes high exactly DEPTH rising edges after rst_i is sampled low.
REQ-018 In CLEAR, wr_en_i and rd_en_i SHALL be ignored: no write, no rd_valid_o, no error capture.
REQ-019 Write: in READY with wr_en_i=1 and addr_i[1:0]=0, mem[index] SHALL take data_i at that edge.
REQ-020 Read: in READY with rd_en_i=1 and addr_i[1:0]=0, data_o SHALL take mem[index] at that edge and rd_valid_o SHALL be 1 for exactly that following cycle (latency 1).
REQ-021 data_o SHALL hold its last value whenever no read is accepted.
REQ-022 If rd_en_i and wr_en_i are both high on the same aligned address, the write SHALL be performed and data_o SHALL return data_i (write-first).
REQ-023 A read in the cycle after a write to the same word SHALL return the newly written data.
REQ-024 Back-to-back reads SHALL each produce one rd_valid_o pulse; no bubbles occur.
REQ-025 Misaligned access (any enable high with addr_i[1:0] != 0, in READY): the access SHALL be dropped, with no memory change and no rd_valid_o.
REQ-026 On a misaligned access, err_o SHALL be set to 1; it stays set until reset.
REQ-027 err_addr_o SHALL capture addr_i on the first misaligned access only; later misaligned accesses do not overwrite it.
REQ-028 Address wrap: the index uses only addr_i[ADDR_W-1:2]; no out-of-range condition exists.

Reset
REQ-029 While rst_i=1 at an edge: state SHALL go to CLEAR, clear counter to 0, data_o to 0, rd_valid_o to 0, ready_o to 0, err_o to 0, and err_addr_o to 0.
REQ-030 Reset asserted mid-CLEAR SHALL restart clearing from word 0; the full DEPTH cycles apply again.
REQ-031 Reset asserted in READY with a read in flight SHALL suppress the pending rd_valid_o pulse.

Verification (ADDR_W=6, DEPTH=16)
REQ-032 Release rst_i -> ready_o=0 for 16 edges and 1 after the 16th; all 16 words then read back 0x00000000.
REQ-033 Write 0xDEADBEEF to 0x08, then read 0x08 -> next cycle data_o=0xDEADBEEF and rd_valid_o=1 for one cycle.
REQ-034 Read and write to 0x10 in the same cycle, write data 0x12345678 -> data_o=0x12345678 next cycle; a later read of 0x10 also returns 0x12345678.
REQ-035 Write 0xAAAAAAAA to 0x05, then 0x0F -> err_o=1, err_addr_o=0x05; word 1 and word 3 still read 0.
REQ-036 Assert rst_i at the 5th CLEAR cycle, write 0x1 to 0x00 during CLEAR -> ready_o rises 16 edges after release; word 0 reads 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core-wide constants for the RISC-V subsystem.
package riscv_pkg;

  localparam int unsigned byte_addr_p = 10;

endpackage

// File: rtl/data_mem.sv
// Word-organised data memory with self-clearing after reset, latency-1 reads,
// write-first collision handling and sticky misaligned-access capture.
module data_mem #(
  parameter int unsigned ADDR_W = riscv_pkg::byte_addr_p
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              rd_valid_o,
  output logic              ready_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] err_addr_o
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned DEPTH = 2 ** IDX_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] clr_cnt;
  logic [31:0]      mem [0:DEPTH-1];

  logic [IDX_W-1:0] idx;
  logic             aligned;
  logic             access;
  logic             wr_ok;
  logic             rd_ok;
  logic             misalign;

  // Request qualification: only READY accepts traffic, misaligned requests are dropped.
  always_comb begin
    idx      = addr_i[ADDR_W-1:2];
    aligned  = (addr_i[1:0] == 2'b00);
    access   = (state == READY) && (wr_en_i || rd_en_i);
    wr_ok    = access && aligned && wr_en_i;
    rd_ok    = access && aligned && rd_en_i;
    misalign = access && !aligned;
  end

  // Storage array: zero-fill during CLEAR, otherwise accepted writes.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (wr_ok) begin
        mem[idx] <= data_i;
      end
    end
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      data_o     <= '0;
      rd_valid_o <= 1'b0;
      ready_o    <= 1'b0;
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else begin
      rd_valid_o <= 1'b0;
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + IDX_W'(1);
          if (clr_cnt == IDX_W'(DEPTH - 1)) begin
            state   <= READY;
            ready_o <= 1'b1;
          end
        end
        READY: begin
          if (rd_ok) begin
            // Same-cycle write to the read word forwards the new data.
            data_o     <= wr_ok ? data_i : mem[idx];
            rd_valid_o <= 1'b1;
          end
          if (misalign && !err_o) begin
            err_o      <= 1'b1;
            err_addr_o <= addr_i;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_cnt <= '0;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
